// File: rtl/ucie_ctl_sb_rsp_handler_if.sv
// Sideband message handshake bundle for the response handler.
// Carries the incoming SB message strobe/code and the response TX handshake.
interface ucie_ctl_sb_rsp_handler_if;
    logic       i_sb_msg_valid;
    logic [4:0] i_sb_msg;
    logic       o_sb_tx_valid;
    logic [4:0] o_sb_tx_msg;
    logic       i_sb_tx_ready;

    modport master (
        output i_sb_msg_valid,
        output i_sb_msg,
        output i_sb_tx_ready,
        input  o_sb_tx_valid,
        input  o_sb_tx_msg
    );

    modport slave (
        input  i_sb_msg_valid,
        input  i_sb_msg,
        input  i_sb_tx_ready,
        output o_sb_tx_valid,
        output o_sb_tx_msg
    );
endinterface

// File: rtl/ucie_ctl_sb_rsp_handler.sv
// Remote-partner sideband response handler: decodes SB messages, raises
// events/requests to the CNTL FSM and sends RSP_ACTIVE / RSP_LINKRESET.
// Ports: i_clk, i_rst (sync, active high); sb (slave: RX msg strobe/code,
// TX valid/msg/ready); i_rx_open, i_linkreset_ack, i_abort permits/flush;
// o_rmt_* request levels and receive pulses, o_adv_cap_rcvd, o_unexp_msg,
// o_timeout. All outputs are registered.
module ucie_ctl_sb_rsp_handler #(
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    ucie_ctl_sb_rsp_handler_if.slave      sb,
    input  logic                          i_rx_open,
    input  logic                          i_linkreset_ack,
    input  logic                          i_abort,
    output logic                          o_rmt_active_req,
    output logic                          o_rmt_linkreset_req,
    output logic                          o_rmt_active_rsp,
    output logic                          o_rmt_linkreset_rsp,
    output logic                          o_adv_cap_rcvd,
    output logic                          o_unexp_msg,
    output logic                          o_timeout
);

    // Width floor of 1 keeps the counter legal when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [4:0] MSG_ADV_CAP  = 5'b00000;
    localparam logic [4:0] MSG_REQ_ACT  = 5'b10101;
    localparam logic [4:0] MSG_REQ_LR   = 5'b10111;
    localparam logic [4:0] MSG_RSP_ACT  = 5'b11001;
    localparam logic [4:0] MSG_RSP_LR   = 5'b11011;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_ACT = 3'd1;
    localparam logic [2:0] ST_SEND_ACT = 3'd2;
    localparam logic [2:0] ST_WAIT_LR  = 3'd3;
    localparam logic [2:0] ST_SEND_LR  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             to_d, unexp_d;
    logic             is_ra, is_rl, known, expire;

    assign is_ra = sb.i_sb_msg_valid && (sb.i_sb_msg == MSG_REQ_ACT);
    assign is_rl = sb.i_sb_msg_valid && (sb.i_sb_msg == MSG_REQ_LR);
    assign known = (sb.i_sb_msg == MSG_ADV_CAP) ||
                   (sb.i_sb_msg == MSG_REQ_ACT) ||
                   (sb.i_sb_msg == MSG_REQ_LR)  ||
                   (sb.i_sb_msg == MSG_RSP_ACT) ||
                   (sb.i_sb_msg == MSG_RSP_LR);
    assign expire = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        to_d    = 1'b0;
        unexp_d = sb.i_sb_msg_valid && !known;
        case (state_q)
            ST_IDLE: begin
                if (is_ra) begin
                    state_d = ST_WAIT_ACT;
                    cnt_d   = '0;
                end else if (is_rl) begin
                    state_d = ST_WAIT_LR;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_ACT: begin
                // A linkreset request preempts the pending activation.
                if (is_rl) begin
                    state_d = ST_WAIT_LR;
                    cnt_d   = '0;
                end else if (i_rx_open) begin
                    state_d = ST_SEND_ACT;
                end else if (expire) begin
                    state_d = ST_IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND_ACT: begin
                if (is_rl) pend_d = 1'b1;
                if (sb.i_sb_tx_ready) begin
                    pend_d = 1'b0;
                    if (pend_q || is_rl) begin
                        state_d = ST_WAIT_LR;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_LR: begin
                if (is_ra) unexp_d = 1'b1;
                if (i_linkreset_ack) begin
                    state_d = ST_SEND_LR;
                end else if (expire) begin
                    state_d = ST_IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND_LR: begin
                if (is_ra) unexp_d = 1'b1;
                if (sb.i_sb_tx_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_abort) begin
            state_q             <= ST_IDLE;
            cnt_q               <= '0;
            pend_q              <= 1'b0;
            sb.o_sb_tx_valid    <= 1'b0;
            sb.o_sb_tx_msg      <= 5'b00000;
            o_rmt_active_req    <= 1'b0;
            o_rmt_linkreset_req <= 1'b0;
            o_rmt_active_rsp    <= 1'b0;
            o_rmt_linkreset_rsp <= 1'b0;
            o_adv_cap_rcvd      <= 1'b0;
            o_unexp_msg         <= 1'b0;
            o_timeout           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pend_q           <= pend_d;
            sb.o_sb_tx_valid <= (state_d == ST_SEND_ACT) ||
                                (state_d == ST_SEND_LR);
            sb.o_sb_tx_msg   <= (state_d == ST_SEND_ACT) ? MSG_RSP_ACT :
                                (state_d == ST_SEND_LR)  ? MSG_RSP_LR  :
                                5'b00000;
            o_rmt_active_req <= (state_d == ST_WAIT_ACT) ||
                                (state_d == ST_SEND_ACT);
            o_rmt_linkreset_req <= (state_d == ST_WAIT_LR) ||
                                   (state_d == ST_SEND_LR) || pend_d;
            o_rmt_active_rsp <= sb.i_sb_msg_valid &&
                                (sb.i_sb_msg == MSG_RSP_ACT);
            o_rmt_linkreset_rsp <= sb.i_sb_msg_valid &&
                                   (sb.i_sb_msg == MSG_RSP_LR);
            o_adv_cap_rcvd   <= sb.i_sb_msg_valid &&
                                (sb.i_sb_msg == MSG_ADV_CAP);
            o_unexp_msg      <= unexp_d;
            o_timeout        <= to_d;
        end
    end

endmodule

// File: tb/tb_ucie_ctl_sb_rsp_handler.sv
// Self-checking bench for ucie_ctl_sb_rsp_handler (TIMEOUT_CYCLES = 8).
// Decode table, directed corner sequences and a randomized model comparison.
module tb_ucie_ctl_sb_rsp_handler;

    localparam int T = 8;
    localparam logic [4:0] ADV = 5'b00000;
    localparam logic [4:0] RQA = 5'b10101;
    localparam logic [4:0] RQL = 5'b10111;
    localparam logic [4:0] RSA = 5'b11001;
    localparam logic [4:0] RSL = 5'b11011;

    logic clk = 1'b0;
    logic rst;
    logic rx_open, lr_ack, abort;
    logic areq, lreq, ra, rl, adv, ux, to;

    always #5 clk = ~clk;

    ucie_ctl_sb_rsp_handler_if sb_if ();

    ucie_ctl_sb_rsp_handler #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .sb                  (sb_if),
        .i_rx_open           (rx_open),
        .i_linkreset_ack     (lr_ack),
        .i_abort             (abort),
        .o_rmt_active_req    (areq),
        .o_rmt_linkreset_req (lreq),
        .o_rmt_active_rsp    (ra),
        .o_rmt_linkreset_rsp (rl),
        .o_adv_cap_rcvd      (adv),
        .o_unexp_msg         (ux),
        .o_timeout           (to)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding-work flags plus a count of WAIT cycles.
    bit act_wait, act_send, lr_wait, lr_send, lr_queued;
    int waited;
    logic [12:0] exp_o;

    function automatic logic [12:0] pk(
        logic v, logic [4:0] m, logic a, logic l,
        logic pa, logic pl, logic pc, logic pu, logic pt);
        return {v, m, a, l, pa, pl, pc, pu, pt};
    endfunction

    function automatic logic [12:0] got();
        return pk(sb_if.o_sb_tx_valid, sb_if.o_sb_tx_msg, areq, lreq,
                  ra, rl, adv, ux, to);
    endfunction

    task automatic model_step();
        logic v;
        logic [4:0] c;
        bit q_ra, q_rl, p_ra, p_rl, p_adv, p_ux, p_to;
        v = sb_if.i_sb_msg_valid;
        c = sb_if.i_sb_msg;
        if (rst || abort) begin
            act_wait = 0; act_send = 0; lr_wait = 0;
            lr_send = 0; lr_queued = 0; waited = 0;
            exp_o = '0;
            return;
        end
        q_ra  = v && c == RQA;
        q_rl  = v && c == RQL;
        p_ra  = v && c == RSA;
        p_rl  = v && c == RSL;
        p_adv = v && c == ADV;
        p_ux  = v && !(c inside {ADV, RQA, RQL, RSA, RSL});
        p_to  = 0;
        if (act_send) begin
            if (q_rl) lr_queued = 1;
            if (sb_if.i_sb_tx_ready) begin
                act_send = 0;
                if (lr_queued) begin
                    lr_wait = 1;
                    waited = 1;
                end
                lr_queued = 0;
            end
        end else if (lr_send) begin
            if (q_ra) p_ux = 1;
            if (sb_if.i_sb_tx_ready) lr_send = 0;
        end else if (act_wait) begin
            if (q_rl) begin
                act_wait = 0; lr_wait = 1; waited = 1;
            end else if (rx_open) begin
                act_wait = 0; act_send = 1;
            end else if (waited >= T) begin
                act_wait = 0; p_to = 1;
            end else waited++;
        end else if (lr_wait) begin
            if (q_ra) p_ux = 1;
            if (lr_ack) begin
                lr_wait = 0; lr_send = 1;
            end else if (waited >= T) begin
                lr_wait = 0; p_to = 1;
            end else waited++;
        end else begin
            if (q_ra) begin
                act_wait = 1; waited = 1;
            end else if (q_rl) begin
                lr_wait = 1; waited = 1;
            end
        end
        exp_o = pk(act_send | lr_send,
                   act_send ? RSA : (lr_send ? RSL : 5'b0),
                   act_wait | act_send,
                   lr_wait | lr_send | lr_queued,
                   p_ra, p_rl, p_adv, p_ux, p_to);
    endtask

    task automatic chk(string name, logic [12:0] g, logic [12:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%b want=%b t=%0t", name, g, e, $time);
        end
    endtask

    task automatic tick(string name);
        model_step();
        @(posedge clk);
        #1;
        chk({name, "/model"}, got(), exp_o);
    endtask

    task automatic set_in(logic v, logic [4:0] m, logic rx,
                          logic ack, logic ab, logic rdy);
        sb_if.i_sb_msg_valid = v;
        sb_if.i_sb_msg       = m;
        rx_open              = rx;
        lr_ack               = ack;
        abort                = ab;
        sb_if.i_sb_tx_ready  = rdy;
    endtask

    task automatic idle_in();
        set_in(0, 5'b0, 0, 0, 0, 1);
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  m;
        logic        ab;
        logic [12:0] e;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, RSA, 1'b0, pk(0, 0, 0, 0, 1, 0, 0, 0, 0)};
        tbl[1] = '{1'b1, RSL, 1'b0, pk(0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[2] = '{1'b1, ADV, 1'b0, pk(0, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[3] = '{1'b1, 5'b01111, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[4] = '{1'b0, 5'b01111, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5] = '{1'b1, 5'b11111, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[6] = '{1'b1, RSA, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[7] = '{1'b1, 5'b00001, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[8] = '{1'b0, ADV, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        rst = 1;
        idle_in();
        tick("rst0");
        tick("rst1");
        chk("reset_state", got(), '0);
        rst = 0;

        // Decode pulses from IDLE, one cycle each.
        foreach (tbl[i]) begin
            set_in(tbl[i].v, tbl[i].m, 0, 0, tbl[i].ab, 1);
            tick("tbl");
            chk($sformatf("tbl%0d", i), got(), tbl[i].e);
        end
        idle_in();
        tick("tbl_end");
        chk("tbl_quiet", got(), '0);

        // Earliest RSP_ACTIVE.
        set_in(1, RQA, 1, 0, 0, 1);
        tick("t1a");
        chk("t1_req", got(), pk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        set_in(0, 0, 1, 0, 0, 1);
        tick("t1b");
        chk("t1_send", got(), pk(1, RSA, 1, 0, 0, 0, 0, 0, 0));
        tick("t1c");
        chk("t1_idle", got(), '0);

        // Timeout after T WAIT cycles.
        set_in(1, RQA, 0, 0, 0, 1);
        tick("t2a");
        idle_in();
        for (int i = 0; i < T - 1; i++) begin
            tick("t2w");
            chk("t2_wait", got(), pk(0, 0, 1, 0, 0, 0, 0, 0, 0));
        end
        tick("t2x");
        chk("t2_timeout", got(), pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick("t2y");
        chk("t2_after", got(), '0);

        // RSP_ACTIVE held under backpressure, queued linkreset.
        set_in(1, RQA, 1, 0, 0, 0);
        tick("t3a");
        set_in(0, 0, 1, 0, 0, 0);
        tick("t3b");
        set_in(1, RQL, 1, 0, 0, 0);
        tick("t3c");
        chk("t3_pend", got(), pk(1, RSA, 1, 1, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0, 0);
        tick("t3d");
        chk("t3_hold", got(), pk(1, RSA, 1, 1, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 0, 0, 1);
        tick("t3e");
        chk("t3_waitlr", got(), pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        set_in(0, 0, 0, 1, 0, 1);
        tick("t3f");
        chk("t3_sendlr", got(), pk(1, RSL, 0, 1, 0, 0, 0, 0, 0));
        idle_in();
        tick("t3g");
        chk("t3_idle", got(), '0);

        // Linkreset preempts a waiting activation.
        set_in(1, RQA, 0, 0, 0, 1);
        tick("t4a");
        set_in(1, RQL, 0, 0, 0, 1);
        tick("t4b");
        chk("t4_preempt", got(), pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        set_in(1, RQA, 1, 0, 0, 1);
        tick("t4c");
        chk("t4_reqact_unexp", got(), pk(0, 0, 0, 1, 0, 0, 0, 1, 0));
        set_in(0, 0, 1, 0, 0, 1);
        tick("t4d");
        chk("t4_no_rspact", got(), pk(0, 0, 0, 1, 0, 0, 0, 0, 0));

        // Abort during SEND_LR under backpressure; message discarded.
        set_in(0, 0, 0, 1, 0, 0);
        tick("t6a");
        chk("t6_sendlr", got(), pk(1, RSL, 0, 1, 0, 0, 0, 0, 0));
        set_in(1, RQA, 0, 0, 1, 0);
        tick("t6b");
        chk("t6_abort", got(), '0);
        idle_in();
        tick("t6c");

        // Randomized run against the model.
        for (int n = 0; n < 4000; n++) begin
            logic [4:0] m;
            int k;
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2: m = RQA;
                3, 4: m = RQL;
                5: m = RSA;
                6: m = RSL;
                7: m = ADV;
                default: m = 5'($urandom);
            endcase
            set_in(($urandom_range(0, 9) < 3), m,
                   ($urandom_range(0, 9) < 2),
                   ($urandom_range(0, 9) < 2),
                   ($urandom_range(0, 99) < 2),
                   ($urandom_range(0, 1) == 1));
            rst = ($urandom_range(0, 199) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
